legv8_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the LEGv8 ARM datapath. It replaces single-cycle control decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives every datapath strobe (PC, IR, register file, memory, ALU) from the latched opcode `instr_31_21`. It also handshakes with a variable-latency memory and traps illegal opcodes and memory timeouts.

---
 rtl/legv8_multicycle_ctrl_pkg.sv | 59 +++++
 rtl/legv8_opcode_decode.sv | 37 +++
 rtl/legv8_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller and its opcode decoder.
package legv8_multicycle_ctrl_pkg;

  localparam int unsigned OPC_W    = 11;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned WAIT_W   = 8;

  // Exact-match opcodes
  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;

  // Masked opcodes (low bits belong to the immediate field)
  localparam logic [OPC_W-1:0] OPC_CBZ      = 11'b10110100000;
  localparam logic [OPC_W-1:0] OPC_CBZ_MASK = 11'b11111111000;
  localparam logic [OPC_W-1:0] OPC_B        = 11'b00010100000;
  localparam logic [OPC_W-1:0] OPC_B_MASK   = 11'b11111100000;

  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_ORR    = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'b0111;

  localparam logic [PC_SRC_W-1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_COND   = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_UNCOND = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LDUR    = 3'd2,
    CLS_STUR    = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5
  } class_t;

  // True when the don't-care-masked opcode matches the pattern
  function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                     input logic [OPC_W-1:0] pattern,
                                     input logic [OPC_W-1:0] mask);
    return (opc & mask) == (pattern & mask);
  endfunction

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode classifier; also yields the ALU operation for R-types.
module legv8_opcode_decode
  import legv8_multicycle_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  output class_t              op_class,
  output logic [ALU_OP_W-1:0] rtype_alu_op
);

  // Priority-free decode: every legal pattern is disjoint from the others
  always_comb begin
    op_class     = CLS_ILLEGAL;
    rtype_alu_op = ALU_AND;
    if (opcode == OPC_ADD) begin
      op_class     = CLS_RTYPE;
      rtype_alu_op = ALU_ADD;
    end else if (opcode == OPC_SUB) begin
      op_class     = CLS_RTYPE;
      rtype_alu_op = ALU_SUB;
    end else if (opcode == OPC_AND) begin
      op_class     = CLS_RTYPE;
      rtype_alu_op = ALU_AND;
    end else if (opcode == OPC_ORR) begin
      op_class     = CLS_RTYPE;
      rtype_alu_op = ALU_ORR;
    end else if (opcode == OPC_LDUR) begin
      op_class = CLS_LDUR;
    end else if (opcode == OPC_STUR) begin
      op_class = CLS_STUR;
    end else if (opc_match(opcode, OPC_CBZ, OPC_CBZ_MASK)) begin
      op_class = CLS_CBZ;
    end else if (opc_match(opcode, OPC_B, OPC_B_MASK)) begin
      op_class = CLS_B;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake, timeout trap and illegal-opcode trap.
module legv8_multicycle_ctrl
  import legv8_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPC_W-1:0]    instr_31_21,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg2loc,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                fault,
  output logic [STATE_W-1:0]  state
);

  state_t              cur_state;
  state_t              nxt_state;
  class_t              cls_q;
  class_t              dec_class;
  logic [ALU_OP_W-1:0] alu_q;
  logic [ALU_OP_W-1:0] dec_alu;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_hit;

  legv8_opcode_decode u_decode (
    .opcode       (instr_31_21),
    .op_class     (dec_class),
    .rtype_alu_op (dec_alu)
  );

  // A ready in the limit cycle wins, so the trap needs ready low
  assign timeout_hit = !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign state       = cur_state;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= ST_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Class register, loaded once per instruction at the end of DECODE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cls_q <= CLS_ILLEGAL;
      alu_q <= ALU_AND;
    end else if (cur_state == ST_DECODE) begin
      cls_q <= dec_class;
      alu_q <= dec_alu;
    end
  end

  // Memory wait counter: restarts on every state change, counts unready
  // cycles while a FETCH or MEM access is outstanding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (nxt_state != cur_state) begin
      wait_cnt <= '0;
    end else if (((cur_state == ST_FETCH) || (cur_state == ST_MEM)) && !mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky fault flag, raised together with entry into FAULT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (nxt_state == ST_FAULT) begin
      fault <= 1'b1;
    end
  end

  // Next-state logic; DECODE steers on the live decode since the class
  // register only loads at the end of that cycle
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_FETCH: begin
        if (mem_ready) begin
          nxt_state = ST_DECODE;
        end else if (timeout_hit) begin
          nxt_state = ST_FAULT;
        end
      end
      ST_DECODE: begin
        nxt_state = (dec_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_RTYPE:          nxt_state = ST_WB;
          CLS_LDUR, CLS_STUR: nxt_state = ST_MEM;
          CLS_CBZ, CLS_B:     nxt_state = ST_FETCH;
          default:            nxt_state = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          nxt_state = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (timeout_hit) begin
          nxt_state = ST_FAULT;
        end
      end
      ST_WB:    nxt_state = ST_FETCH;
      ST_FAULT: nxt_state = ST_FAULT;
      default:  nxt_state = ST_FAULT;
    endcase
  end

  // Datapath strobes from state and latched class; all held low in reset
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PLUS4;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg2loc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_AND;
    instr_done = 1'b0;
    if (!reset) begin
      case (cur_state)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PLUS4;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_RTYPE: begin
              alu_src = 1'b0;
              alu_op  = alu_q;
            end
            CLS_LDUR, CLS_STUR: begin
              alu_src = 1'b1;
              alu_op  = ALU_ADD;
            end
            CLS_CBZ: begin
              reg2loc    = 1'b1;
              alu_op     = ALU_PASS_B;
              instr_done = 1'b1;
              if (alu_zero) begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_COND;
              end
            end
            CLS_B: begin
              pc_write   = 1'b1;
              pc_src     = PC_SRC_UNCOND;
              instr_done = 1'b1;
            end
            default: begin
            end
          endcase
        end
        ST_MEM: begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
          if (cls_q == CLS_LDUR) begin
            mem_read = 1'b1;
          end
          if (cls_q == CLS_STUR) begin
            mem_write  = 1'b1;
            instr_done = mem_ready;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (cls_q == CLS_LDUR) begin
            mem_to_reg = 1'b1;
          end else begin
            alu_op = alu_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: each driven cycle pushes the
// expected strobe picture, the negedge monitor pops and compares it.
module tb_legv8_multicycle_ctrl;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_ORR = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_PSB = 4'b0111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic       reg2loc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       fault;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    obs_t  v;
    obs_t  m;
    string tag;
  } sb_t;

  logic        clock;
  logic        reset;
  logic [10:0] instr_31_21;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        reg_write;
  logic        reg2loc;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        instr_done;
  logic        fault;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  sb_t sb[$];

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_31_21 (instr_31_21),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg2loc     (reg2loc),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .instr_done  (instr_done),
    .fault       (fault),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: compare the live outputs against the oldest pending expectation
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      sb_t  e;
      obs_t o;
      e = sb.pop_front();
      o.pc_write   = pc_write;
      o.pc_src     = pc_src;
      o.ir_write   = ir_write;
      o.reg_write  = reg_write;
      o.reg2loc    = reg2loc;
      o.mem_read   = mem_read;
      o.mem_write  = mem_write;
      o.mem_to_reg = mem_to_reg;
      o.alu_src    = alu_src;
      o.alu_op     = alu_op;
      o.instr_done = instr_done;
      o.fault      = fault;
      o.st         = state;
      check(e.tag, 32'(o & e.m), 32'(e.v & e.m));
    end
  end

  function automatic obs_t o_st(input logic [2:0] s);
    obs_t o;
    o    = '0;
    o.st = s;
    return o;
  endfunction

  function automatic obs_t full();
    obs_t m;
    m = '1;
    return m;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be in it
  task automatic step(input obs_t v, input obs_t m, input logic rdy, input logic z,
                      input string tag);
    sb_t e;
    mem_ready = rdy;
    alu_zero  = z;
    e.v   = v;
    e.m   = m;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(o_st(3'd0), full(), 1'b1, 1'b1, tag);
    step(o_st(3'd0), full(), 1'b1, 1'b1, tag);
    reset = 1'b0;
  endtask

  task automatic t_fetch(input int waits);
    obs_t e;
    e = o_st(3'd0);
    e.mem_read = 1'b1;
    for (int i = 0; i < waits; i++) step(e, full(), 1'b0, 1'b1, "fetch_wait");
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    step(e, full(), 1'b1, 1'b0, "fetch_ready");
    step(o_st(3'd1), full(), 1'b1, 1'b1, "decode");
  endtask

  task automatic run_rtype(input logic [10:0] opc, input logic [3:0] aop, input int fw);
    obs_t e;
    instr_31_21 = opc;
    t_fetch(fw);
    e = o_st(3'd2);
    e.alu_op = aop;
    step(e, full(), 1'b1, 1'b1, "exec_r");
    e = o_st(3'd4);
    e.reg_write  = 1'b1;
    e.alu_op     = aop;
    e.instr_done = 1'b1;
    step(e, full(), 1'b1, 1'b0, "wb_r");
  endtask

  // LDUR/STUR up to the MEM ready cycle
  task automatic run_mem(input logic is_ld, input int fw, input int mw);
    obs_t e;
    obs_t m;
    instr_31_21 = is_ld ? OP_LDUR : OP_STUR;
    t_fetch(fw);
    e = o_st(3'd2);
    e.alu_op  = A_ADD;
    e.alu_src = 1'b1;
    step(e, full(), 1'b1, 1'b1, "exec_mem");
    e.st        = 3'd3;
    e.mem_read  = is_ld;
    e.mem_write = !is_ld;
    for (int i = 0; i < mw; i++) step(e, full(), 1'b0, 1'b1, "mem_wait");
    e.instr_done = !is_ld;
    step(e, full(), 1'b1, 1'b0, "mem_ready");
    if (is_ld) begin
      e = o_st(3'd4);
      e.reg_write  = 1'b1;
      e.mem_to_reg = 1'b1;
      e.instr_done = 1'b1;
      m = full();
      m.alu_op  = '0;
      m.alu_src = 1'b0;
      step(e, m, 1'b1, 1'b0, "wb_ld");
    end
  endtask

  task automatic run_branch(input logic is_cbz, input logic z);
    obs_t e;
    obs_t m;
    instr_31_21 = is_cbz ? OP_CBZ : OP_B;
    t_fetch(0);
    e = o_st(3'd2);
    m = full();
    m.alu_src    = 1'b0;
    e.instr_done = 1'b1;
    if (is_cbz) begin
      e.reg2loc  = 1'b1;
      e.alu_op   = A_PSB;
      e.pc_write = z;
      e.pc_src   = z ? 2'd1 : 2'd0;
      if (!z) m.pc_src = '0;
    end else begin
      e.pc_write = 1'b1;
      e.pc_src   = 2'd2;
      m.alu_op   = '0;
    end
    step(e, m, 1'b1, z, is_cbz ? "exec_cbz" : "exec_b");
  endtask

  initial begin
    obs_t e;
    reset       = 1'b1;
    instr_31_21 = '0;
    alu_zero    = 1'b0;
    mem_ready   = 1'b0;
    @(posedge clock);
    #1;
    do_reset("reset");

    run_rtype(OP_ADD, A_ADD, 0);
    run_rtype(OP_SUB, A_SUB, 1);
    run_rtype(OP_AND, A_AND, 0);
    run_rtype(OP_ORR, A_ORR, 2);
    run_mem(1'b1, 0, 3);
    run_mem(1'b0, 1, 0);
    run_branch(1'b1, 1'b1);
    run_branch(1'b1, 1'b0);
    run_branch(1'b0, 1'b1);

    // Illegal opcode traps and stays trapped until reset
    instr_31_21 = OP_ILL;
    t_fetch(0);
    e = o_st(3'd5);
    e.fault = 1'b1;
    for (int i = 0; i < 20; i++) step(e, full(), 1'(i % 2), 1'b1, "fault_hold");
    do_reset("fault_reset");

    // Fetch timeout: four wait cycles, then the limit cycle without ready
    instr_31_21 = OP_ADD;
    e = o_st(3'd0);
    e.mem_read = 1'b1;
    for (int i = 0; i < 4; i++) step(e, full(), 1'b0, 1'b0, "to_wait");
    step(e, full(), 1'b0, 1'b0, "to_limit");
    e = o_st(3'd5);
    e.fault = 1'b1;
    step(e, full(), 1'b0, 1'b0, "to_fault");
    do_reset("to_reset");

    // Ready on the limit cycle still completes the fetch
    run_rtype(OP_ADD, A_ADD, 4);

    // Reset during a pending STUR write aborts it immediately
    instr_31_21 = OP_STUR;
    t_fetch(0);
    e = o_st(3'd2);
    e.alu_op  = A_ADD;
    e.alu_src = 1'b1;
    step(e, full(), 1'b0, 1'b0, "stur_exec");
    e.st        = 3'd3;
    e.mem_write = 1'b1;
    step(e, full(), 1'b0, 1'b0, "stur_mem");
    step(e, full(), 1'b0, 1'b0, "stur_mem");
    do_reset("mid_mem_reset");
    run_rtype(OP_AND, A_AND, 0);

    @(negedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
